// File: rtl/uart_pkg.sv
// Shared UART-side definitions: tx_line FSM states, line-termination phases and the
// control characters also used by the line receiver.
package uart_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned COUNT_W     = 8;
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned ACK_CNT_W   = 2;

  localparam logic [DATA_W-1:0] CHAR_CR  = 8'h0D;
  localparam logic [DATA_W-1:0] CHAR_LF  = 8'h0A;
  localparam logic [DATA_W-1:0] CHAR_NUL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RAM,
    ST_CHECK,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_DONE
  } tx_line_state_e;

  typedef enum logic [1:0] {
    PH_PAYLOAD,
    PH_CR,
    PH_LF
  } term_phase_e;

endpackage

// File: rtl/tx_line_if.sv
// Command, RAM read port and UART transmitter handshake seen by tx_line.
interface tx_line_if;

  logic                             start;
  logic [uart_pkg::ADDR_W-1:0]      start_addr;
  logic [uart_pkg::ADDR_W-1:0]      addr;
  logic [uart_pkg::DATA_W-1:0]      data_read;
  logic                             tx_start;
  logic [uart_pkg::DATA_W-1:0]      tx_data;
  logic                             tx_done;
  logic                             busy;
  logic                             tx_line_done;

  // tx_line side: drives the RAM address and the UART, reports status.
  modport master (
    input  start,
    input  start_addr,
    output addr,
    input  data_read,
    output tx_start,
    output tx_data,
    input  tx_done,
    output busy,
    output tx_line_done
  );

  // Environment side: requester, RAM and UART transmitter.
  modport slave (
    output start,
    output start_addr,
    input  addr,
    output data_read,
    input  tx_start,
    input  tx_data,
    output tx_done,
    input  busy,
    input  tx_line_done
  );

endinterface

// File: rtl/tx_line.sv
// Reads a NUL-terminated string from RAM and sends it, followed by CR LF, through
// the UART transmitter one byte at a time.
module tx_line
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic      clock,
  input  logic      reset,
  tx_line_if.master bus
);

  localparam logic [COUNT_W-1:0]   COUNT_MAX = COUNT_W'(MAX_LEN);
  localparam logic [ACK_CNT_W-1:0] ACK_LAST  = ACK_CNT_W'(ACK_TIMEOUT - 1);

  tx_line_state_e       state, state_nxt;
  term_phase_e          phase_q, phase_nxt;
  logic [ADDR_W-1:0]    addr_q, addr_nxt;
  logic [COUNT_W-1:0]   count_q, count_nxt;
  logic [DATA_W-1:0]    tx_data_q, tx_data_nxt;
  logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_nxt;
  logic                 tx_start_q;
  logic                 busy_q;
  logic                 line_done_q;

  // State register plus datapath registers; pulse/status outputs decoded from next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      phase_q     <= PH_PAYLOAD;
      addr_q      <= '0;
      count_q     <= '0;
      tx_data_q   <= '0;
      ack_cnt_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_q     <= phase_nxt;
      addr_q      <= addr_nxt;
      count_q     <= count_nxt;
      tx_data_q   <= tx_data_nxt;
      ack_cnt_q   <= ack_cnt_nxt;
      tx_start_q  <= (state_nxt == ST_SEND);
      busy_q      <= (state_nxt != ST_IDLE);
      line_done_q <= (state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath update for fetch / send / terminate sequencing.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_q;
    addr_nxt    = addr_q;
    count_nxt   = count_q;
    tx_data_nxt = tx_data_q;
    ack_cnt_nxt = ack_cnt_q;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          addr_nxt  = bus.start_addr;
          count_nxt = '0;
          state_nxt = ST_FETCH;
        end
      end

      // RAM registers addr during this cycle.
      ST_FETCH: state_nxt = ST_WAIT_RAM;

      // data_read becomes valid for addr at the end of this cycle.
      ST_WAIT_RAM: state_nxt = ST_CHECK;

      // Length limit and NUL both end the payload; either way CR goes next.
      ST_CHECK: begin
        if ((bus.data_read == CHAR_NUL) || (count_q == COUNT_MAX)) begin
          tx_data_nxt = CHAR_CR;
          phase_nxt   = PH_CR;
        end else begin
          tx_data_nxt = bus.data_read;
          phase_nxt   = PH_PAYLOAD;
        end
        state_nxt = ST_SEND;
      end

      ST_SEND: begin
        ack_cnt_nxt = '0;
        state_nxt   = ST_WAIT_ACK;
      end

      // A transmitter that never drops tx_done is taken as already finished.
      ST_WAIT_ACK: begin
        if (!bus.tx_done) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_nxt = ST_WAIT_DONE;
        end else begin
          ack_cnt_nxt = ack_cnt_q + ACK_CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          case (phase_q)
            PH_PAYLOAD: begin
              addr_nxt  = addr_q + ADDR_W'(1);
              count_nxt = count_q + COUNT_W'(1);
              state_nxt = ST_FETCH;
            end
            PH_CR: begin
              tx_data_nxt = CHAR_LF;
              phase_nxt   = PH_LF;
              state_nxt   = ST_SEND;
            end
            default: state_nxt = ST_DONE;
          endcase
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.addr         = addr_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.busy         = busy_q;
  assign bus.tx_line_done = line_done_q;

endmodule

// File: tb/tb_tx_line.sv
// Randomized self-checking bench for tx_line: registered-read RAM, behavioural UART
// transmitter and a string-walking reference model; two instances (MAX_LEN 255 and 3).
module tb_tx_line;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  tx_line_if bus_a ();
  tx_line_if bus_b ();

  tx_line #(.MAX_LEN(255)) dut_a (.clock(clock), .reset(reset), .bus(bus_a.master));
  tx_line #(.MAX_LEN(3))   dut_b (.clock(clock), .reset(reset), .bus(bus_b.master));

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];

  // Registered-read RAM ports, one per instance, sharing the same contents.
  logic [7:0] rd_a = 8'h00;
  logic [7:0] rd_b = 8'h00;
  always @(posedge clock) rd_a <= mem[bus_a.addr];
  always @(posedge clock) rd_b <= mem[bus_b.addr];
  assign bus_a.data_read = rd_a;
  assign bus_b.data_read = rd_b;

  // UART TX models: tx_done drops one cycle after tx_start, rises 20 cycles later.
  logic ua_done = 1'b1, ua_drop = 1'b0;
  int   ua_low  = 0;
  logic ub_done = 1'b1, ub_drop = 1'b0;
  int   ub_low  = 0;
  assign bus_a.tx_done = ua_done;
  assign bus_b.tx_done = ub_done;

  always @(posedge clock) begin
    if (ua_low > 0) begin
      ua_low <= ua_low - 1;
      if (ua_low == 1) ua_done <= 1'b1;
    end else if (ua_drop) begin
      ua_drop <= 1'b0;
      ua_done <= 1'b0;
      ua_low  <= 20;
    end
    if (bus_a.tx_start) ua_drop <= 1'b1;
  end

  always @(posedge clock) begin
    if (ub_low > 0) begin
      ub_low <= ub_low - 1;
      if (ub_low == 1) ub_done <= 1'b1;
    end else if (ub_drop) begin
      ub_drop <= 1'b0;
      ub_done <= 1'b0;
      ub_low  <= 20;
    end
    if (bus_b.tx_start) ub_drop <= 1'b1;
  end

  // Output monitors, sampled on the falling edge.
  logic [7:0] got_a[$], got_b[$], at_a[$], at_b[$];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  int done_a = 0, done_b = 0, unstable_a = 0, unstable_b = 0;

  always @(negedge clock) begin
    if (bus_a.tx_start) begin
      got_a.push_back(bus_a.tx_data);
      last_a = bus_a.tx_data;
    end else if ((ua_drop || ua_low > 0) && bus_a.tx_data != last_a) begin
      unstable_a++;
    end
    if (bus_a.tx_line_done) done_a++;
    if (bus_a.busy && (at_a.size() == 0 || at_a[$] != bus_a.addr)) at_a.push_back(bus_a.addr);
  end

  always @(negedge clock) begin
    if (bus_b.tx_start) begin
      got_b.push_back(bus_b.tx_data);
      last_b = bus_b.tx_data;
    end else if ((ub_drop || ub_low > 0) && bus_b.tx_data != last_b) begin
      unstable_b++;
    end
    if (bus_b.tx_line_done) done_b++;
    if (bus_b.busy && (at_b.size() == 0 || at_b[$] != bus_b.addr)) at_b.push_back(bus_b.addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the string until NUL or the length limit, then CR LF.
  logic [7:0] exp_q[$], exp_at[$];
  logic [7:0] exp_fin;

  task automatic model(input logic [7:0] sa, input int unsigned maxlen);
    logic [7:0] a;
    int unsigned n;
    exp_q.delete();
    exp_at.delete();
    a = sa;
    n = 0;
    exp_at.push_back(a);
    while (n < maxlen && mem[a] != 8'h00) begin
      exp_q.push_back(mem[a]);
      a = a + 8'd1;
      n++;
      exp_at.push_back(a);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_fin = a;
  endtask

  logic       drv_start_a = 1'b0, drv_start_b = 1'b0;
  logic [7:0] drv_sa = 8'h00;
  assign bus_a.start      = drv_start_a;
  assign bus_b.start      = drv_start_b;
  assign bus_a.start_addr = drv_sa;
  assign bus_b.start_addr = drv_sa;

  task automatic clear_mon();
    got_a.delete(); got_b.delete(); at_a.delete(); at_b.delete();
    done_a = 0; done_b = 0; unstable_a = 0; unstable_b = 0;
  endtask

  task automatic pulse_start(input bit which, input logic [7:0] sa);
    @(negedge clock);
    drv_sa = sa;
    if (which) drv_start_b = 1'b1; else drv_start_a = 1'b1;
    @(negedge clock);
    drv_start_a = 1'b0;
    drv_start_b = 1'b0;
  endtask

  // Send one line and compare everything observable against the model.
  task automatic run_line(input bit which, input logic [7:0] sa, input bit poke, input string tag);
    int d, n;
    logic [7:0] g[$], t[$];
    model(sa, which ? 3 : 255);
    clear_mon();
    pulse_start(which, sa);
    if (poke) begin
      n = 0;
      for (int i = 0; i < 2000 && n == 0; i++) begin
        @(negedge clock);
        n = which ? got_b.size() : got_a.size();
      end
      repeat (6) @(negedge clock);
      pulse_start(which, sa + 8'h10);
    end
    d = 0;
    for (int i = 0; i < 20000 && d == 0; i++) begin
      @(negedge clock);
      d = which ? done_b : done_a;
    end
    repeat (3) @(negedge clock);
    d = which ? done_b : done_a;
    check_eq({tag, " line_done_pulses"}, d, 1);
    g = which ? got_b : got_a;
    t = which ? at_b : at_a;
    check_eq({tag, " tx_start_count"}, g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      check_eq($sformatf("%s byte%0d", tag, i), g[i], exp_q[i]);
    check_eq({tag, " addr_trace_len"}, t.size(), exp_at.size());
    for (int i = 0; i < exp_at.size() && i < t.size(); i++)
      check_eq($sformatf("%s addr%0d", tag, i), t[i], exp_at[i]);
    check_eq({tag, " final_addr"}, which ? bus_b.addr : bus_a.addr, exp_fin);
    check_eq({tag, " busy_after"}, which ? bus_b.busy : bus_a.busy, 0);
    check_eq({tag, " tx_data_stable"}, which ? unstable_b : unstable_a, 0);
  endtask

  initial begin
    int n, len;
    bit w;
    logic [7:0] sa;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst addr", bus_a.addr, 0);
    check_eq("rst tx_data", bus_a.tx_data, 0);
    check_eq("rst tx_start", bus_a.tx_start, 0);
    check_eq("rst busy", bus_a.busy, 0);
    check_eq("rst line_done", bus_a.tx_line_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic line
    mem[1] = 8'h41; mem[2] = 8'h44; mem[3] = 8'h41; mem[4] = 8'h4D; mem[5] = 8'h00;
    run_line(1'b0, 8'h01, 1'b0, "basic");

    // Empty string
    mem[8'h20] = 8'h00;
    run_line(1'b0, 8'h20, 1'b0, "empty");

    // Address wrap
    mem[8'hFE] = 8'h58; mem[8'hFF] = 8'h59; mem[8'h00] = 8'h00;
    run_line(1'b0, 8'hFE, 1'b0, "wrap");

    // Length limit on the MAX_LEN=3 instance
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63; mem[3] = 8'h64; mem[4] = 8'h65; mem[5] = 8'h00;
    run_line(1'b1, 8'h00, 1'b0, "maxlen");
    check_eq("maxlen no_d", (got_b.size() > 3) ? got_b[3] : 8'h0D, 8'h0D);

    // Start while busy is ignored; the next start is accepted
    run_line(1'b0, 8'h00, 1'b1, "busy_start");
    run_line(1'b0, 8'h01, 1'b0, "after_busy");

    // Reset in the middle of the second byte
    mem[8'h40] = 8'h48; mem[8'h41] = 8'h45; mem[8'h42] = 8'h4C; mem[8'h43] = 8'h4C;
    mem[8'h44] = 8'h4F; mem[8'h45] = 8'h00;
    clear_mon();
    pulse_start(1'b0, 8'h40);
    n = 0;
    for (int i = 0; i < 2000 && n < 2; i++) begin
      @(negedge clock);
      n = got_a.size();
    end
    check_eq("midrst reached_byte2", n, 2);
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst addr", bus_a.addr, 0);
    check_eq("midrst tx_data", bus_a.tx_data, 0);
    check_eq("midrst tx_start", bus_a.tx_start, 0);
    check_eq("midrst busy", bus_a.busy, 0);
    check_eq("midrst line_done", bus_a.tx_line_done, 0);
    n = got_a.size();
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check_eq("midrst no_more_tx", got_a.size(), n);
    check_eq("midrst no_done", done_a, 0);
    run_line(1'b0, 8'h40, 1'b0, "post_rst");

    // Random strings on random addresses, random instance
    for (int k = 0; k < 16; k++) begin
      w   = 1'($urandom_range(0, 1));
      sa  = 8'($urandom);
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) mem[8'(sa + 8'(i))] = 8'($urandom_range(1, 255));
      mem[8'(sa + 8'(len))] = 8'h00;
      run_line(w, sa, 1'b0, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_line.md
Name: tx_line

Overview:
- Transmit-side companion to the line receiver.
- On a start pulse, reads a NUL-terminated byte string from the shared 256x8 RAM, beginning at start_addr.
- Feeds each byte to the UART transmitter using its start/done handshake, then appends CR (0x0D) and LF (0x0A).
- Pulses tx_line_done when the whole line, including CR LF, has been transmitted.

Parameters:
- MAX_LEN, 255: maximum payload bytes read before forcing line termination. Range 1..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to transmit a line. Sampled only in IDLE.
- start_addr  input  8  RAM address of the first character. Captured when start is accepted.
- addr  output  8  RAM read address. The RAM registers the address, so data_read reflects addr one edge later.
- data_read  input  8  RAM read data.
- tx_start  output  1  one-cycle pulse that launches the UART transmitter.
- tx_data  output  8  byte to transmit. Held stable from the tx_start pulse until the byte completes.
- tx_done  input  1  UART transmitter status: high = idle/finished, low = shifting.
- busy  output  1  high in every state except IDLE.
- tx_line_done  output  1  one-cycle pulse after LF completes.

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; addr=0; tx_data=0; tx_start=0; busy=0; tx_line_done=0; length count=0.
- Reset asserted mid-line aborts immediately. No further tx_start is issued; an in-flight UART byte is not recalled.

State sequence:
- IDLE: if start=1, go to FETCH.
  - addr <= start_addr; count <= 0.
  - start is ignored in every other state.
- FETCH: go to WAIT_RAM. This is the cycle in which the RAM registers addr.
- WAIT_RAM: go to CHECK. data_read is now valid for addr.
- CHECK: sample data_read.
  - If data_read == 0x00, or count == MAX_LEN: tx_data <= 0x0D, go to SEND, with the termination phase set to CR.
  - Otherwise: tx_data <= data_read, go to SEND, with the termination phase set to payload.
- SEND: tx_start=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: stay until tx_done=0, then go to WAIT_DONE.
  - If tx_done is still 1 after 4 cycles, treat the byte as completed and go to WAIT_DONE. This guards against a zero-latency transmitter.
- WAIT_DONE: stay until tx_done=1, then advance on the termination phase:
  - payload: addr <= addr+1 (8-bit, 0xFF wraps to 0x00); count <= count+1; go to FETCH.
  - CR: tx_data <= 0x0A; phase becomes LF; go to SEND.
  - LF: go to DONE.
- DONE: tx_line_done=1 for one cycle; go to IDLE.

Timing and arithmetic:
- Minimum per-character overhead: 4 cycles (FETCH, WAIT_RAM, CHECK, SEND), excluding UART time.
- The NUL byte is never transmitted.
- An empty string (NUL at start_addr) transmits only CR LF.
- The MAX_LEN check precedes the NUL check result: exactly MAX_LEN payload bytes are sent, then CR LF.
- addr stays at the last fetched address after the line completes.
- count width is 8 bits and never exceeds MAX_LEN.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum for tx_line.
  - constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_NUL=8'h00. The line receiver uses the same constants.
  - termination-phase enum (PAYLOAD, CR, LF).
- Single flat module; no sub-module required.
- The bench reuses the registered-read RAM model and a behavioural UART TX model. The TX model drops tx_done 1 cycle after tx_start and raises it 20 cycles later.

Test Plan:
- Basic line: RAM[1..5]=41 44 41 4D 00, start_addr=1, start pulse -> tx bytes 41,44,41,4D,0D,0A in order; 6 tx_start pulses; one tx_line_done pulse; busy low afterwards.
- Empty string: RAM[0x20]=00, start_addr=0x20 -> tx bytes 0D,0A only; tx_line_done pulse; addr=0x20.
- Wrap-around: RAM[FE]=58, RAM[FF]=59, RAM[00]=00, start_addr=FE -> tx 58,59,0D,0A; addr sequence FE, FF, 00.
- MAX_LEN limit: MAX_LEN=3, RAM[0..5]=61 62 63 64 65 00, start_addr=0 -> tx 61,62,63,0D,0A; RAM[3] is never sent.
- Start while busy: second start pulse during the first byte's WAIT_DONE -> ignored; exactly one line output; next start after tx_line_done is accepted.
- Reset mid-operation: assert reset during the second byte's WAIT_DONE -> all outputs zero asynchronously; no further tx_start; a fresh start after release sends the full line from the beginning.
